// File: rtl/bank_cmd_queue.sv
// Per-bank command FIFO in front of one bank state machine. Holds the head
// entry steady as a registered valid/command pair until the bank FSM accepts it.
`ifndef MEM_CTR_COMMAND_BITS
`define MEM_CTR_COMMAND_BITS 32
`endif
`ifndef BA_BITS
`define BA_BITS 3
`endif

module bank_cmd_queue #(
  parameter int DEPTH   = 4,
  parameter int CMD_W   = `MEM_CTR_COMMAND_BITS,
  parameter int BA_W    = `BA_BITS,
  parameter int BANK_ID = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [CMD_W-1:0]           in_cmd,
  input  logic [BA_W-1:0]            in_bank,
  output logic                       in_ready,
  output logic                       bank_valid,
  output logic [CMD_W-1:0]           bank_cmd,
  input  logic                       bank_accept,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       full,
  output logic                       empty,
  output logic                       bank_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  logic [CMD_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [OW-1:0]    r_occ;
  logic             r_bank_valid;
  logic [CMD_W-1:0] r_bank_cmd;
  logic             r_err;

  logic             w_full, w_empty;
  logic             w_hs, w_bank_hit, w_push, w_pop, w_err;
  logic [OW-1:0]    w_occ_nxt;
  logic [AW-1:0]    w_rd_inc;
  logic             w_head_ld;
  logic [CMD_W-1:0] w_head_nxt;

  // Full/empty come from the registered count only, so a same-cycle pop
  // never opens in_ready.
  assign w_full     = (r_occ == OW'(DEPTH));
  assign w_empty    = (r_occ == '0);
  assign w_hs       = in_valid && !w_full;
  assign w_bank_hit = (in_bank == BA_W'(BANK_ID));
  assign w_push     = w_hs && w_bank_hit;
  assign w_pop      = bank_accept && r_bank_valid;
  assign w_err      = (w_hs && !w_bank_hit) || (bank_accept && !r_bank_valid);
  assign w_rd_inc   = r_rd_ptr + AW'(1);

  always_comb begin
    w_occ_nxt = r_occ;
    case ({w_push, w_pop})
      2'b10:   w_occ_nxt = r_occ + OW'(1);
      2'b01:   w_occ_nxt = r_occ - OW'(1);
      default: w_occ_nxt = r_occ;
    endcase
  end

  // The head register follows the slot rd_ptr will point at next edge; when
  // that slot is being written this edge, take in_cmd directly.
  always_comb begin
    w_head_ld  = 1'b0;
    w_head_nxt = r_bank_cmd;
    if (w_push && (w_empty || (r_occ == OW'(1) && w_pop))) begin
      w_head_ld  = 1'b1;
      w_head_nxt = in_cmd;
    end else if (w_pop && r_occ > OW'(1)) begin
      w_head_ld  = 1'b1;
      w_head_nxt = r_mem[w_rd_inc];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_occ        <= '0;
      r_bank_valid <= 1'b0;
      r_bank_cmd   <= '0;
      r_err        <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= in_cmd;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= w_rd_inc;
      if (w_head_ld) r_bank_cmd <= w_head_nxt;
      r_occ        <= w_occ_nxt;
      r_bank_valid <= (w_occ_nxt != '0);
      if (w_err) r_err <= 1'b1;
    end
  end

  assign in_ready   = !w_full;
  assign bank_valid = r_bank_valid;
  assign bank_cmd   = r_bank_cmd;
  assign occupancy  = r_occ;
  assign full       = w_full;
  assign empty      = w_empty;
  assign bank_err   = r_err;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (r_occ <= OW'(DEPTH));
      assert (r_bank_valid == !w_empty);
    end
  end
`endif

endmodule

// File: tb/tb_bank_cmd_queue.sv
// Scoreboard bench for bank_cmd_queue: pushes record expected commands,
// accepts pop and compare them, per-scenario tasks check flags inline.
module tb_bank_cmd_queue;
  localparam int DEPTH = 4;
  localparam int CMD_W = 32;
  localparam int BA_W  = 3;
  localparam int OW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [CMD_W-1:0] in_cmd = '0;
  logic [BA_W-1:0]  in_bank = '0;
  logic             in_ready, bank_valid, bank_accept = 1'b0;
  logic [CMD_W-1:0] bank_cmd;
  logic [OW-1:0]    occupancy;
  logic             full, empty, bank_err;

  bank_cmd_queue #(.DEPTH(DEPTH), .CMD_W(CMD_W), .BA_W(BA_W), .BANK_ID(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_cmd(in_cmd), .in_bank(in_bank),
    .in_ready(in_ready), .bank_valid(bank_valid), .bank_cmd(bank_cmd),
    .bank_accept(bank_accept), .occupancy(occupancy), .full(full), .empty(empty),
    .bank_err(bank_err)
  );

  always #5 clk = ~clk;

  int vec = 0;
  int bad = 0;
  logic [CMD_W-1:0] sb[$];
  int               m_occ = 0;
  logic             did_pop;
  logic [CMD_W-1:0] popped, exp_c;

  function automatic logic [CMD_W-1:0] mk_cmd(input logic [15:0] row, input logic [11:0] col,
                                              input logic rw);
    return {row, col, 3'b000, rw};
  endfunction

  // One clock of stimulus; the model decides push/pop from its own occupancy.
  task automatic cyc(input logic v, input logic [CMD_W-1:0] c, input logic [BA_W-1:0] b,
                     input logic acc);
    in_valid = v; in_cmd = c; in_bank = b; bank_accept = acc;
    did_pop = 1'b0;
    if (acc && m_occ > 0) begin
      did_pop = 1'b1;
      popped  = bank_cmd;
    end
    if (v && m_occ < DEPTH && b == '0) sb.push_back(c);
    m_occ = m_occ + ((v && m_occ < DEPTH && b == '0) ? 1 : 0) - (did_pop ? 1 : 0);
    @(posedge clk); #1;
    in_valid = 1'b0; bank_accept = 1'b0;
  endtask

  task automatic test_reset;
    @(posedge clk); #1;
    vec++; if (occupancy !== '0) begin bad++; $display("FAIL rst_occ got=%0d want=0", occupancy); end
    vec++; if ({empty, full, in_ready, bank_valid, bank_err} !== 5'b10100) begin
      bad++; $display("FAIL rst_flags got=%b want=10100", {empty, full, in_ready, bank_valid, bank_err});
    end
    vec++; if (bank_cmd !== '0) begin bad++; $display("FAIL rst_cmd got=%h want=0", bank_cmd); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single;
    logic [CMD_W-1:0] a;
    a = mk_cmd(16'h12, 12'h5, 1'b1);
    cyc(1'b1, a, '0, 1'b0);
    vec++; if (bank_valid !== 1'b1 || bank_cmd !== a || occupancy !== OW'(1)) begin
      bad++; $display("FAIL single_push got v=%b cmd=%h occ=%0d want v=1 cmd=%h occ=1",
                      bank_valid, bank_cmd, occupancy, a);
    end
    cyc(1'b0, '0, '0, 1'b1);
    exp_c = sb.pop_front();
    vec++; if (!did_pop || popped !== exp_c) begin bad++; $display("FAIL single_pop got=%h want=%h", popped, exp_c); end
    vec++; if (empty !== 1'b1 || bank_valid !== 1'b0) begin
      bad++; $display("FAIL single_empty got e=%b v=%b want e=1 v=0", empty, bank_valid);
    end
  endtask

  task automatic test_fill;
    for (int i = 1; i <= 4; i++) cyc(1'b1, mk_cmd(16'h100 + 16'(i), 12'(i), 1'b0), '0, 1'b0);
    vec++; if (occupancy !== OW'(4) || full !== 1'b1 || in_ready !== 1'b0) begin
      bad++; $display("FAIL fill got occ=%0d full=%b rdy=%b want 4 1 0", occupancy, full, in_ready);
    end
    cyc(1'b1, mk_cmd(16'h1FF, 12'hFFF, 1'b1), '0, 1'b0);
    vec++; if (occupancy !== OW'(4)) begin bad++; $display("FAIL fill_holdoff got occ=%0d want=4", occupancy); end
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b0, '0, '0, 1'b1);
      exp_c = sb.pop_front();
      vec++; if (!did_pop || popped !== exp_c) begin
        bad++; $display("FAIL fill_order%0d got=%h want=%h", i, popped, exp_c);
      end
    end
    vec++; if (occupancy !== '0 || empty !== 1'b1) begin
      bad++; $display("FAIL fill_drain got occ=%0d e=%b want 0 1", occupancy, empty);
    end
  endtask

  task automatic test_full_pushpop;
    for (int i = 1; i <= 4; i++) cyc(1'b1, mk_cmd(16'h200 + 16'(i), 12'h20, 1'b0), '0, 1'b0);
    cyc(1'b1, mk_cmd(16'h2FF, 12'h2F, 1'b1), '0, 1'b1);
    exp_c = sb.pop_front();
    vec++; if (!did_pop || popped !== exp_c) begin bad++; $display("FAIL fullpp_pop got=%h want=%h", popped, exp_c); end
    vec++; if (occupancy !== OW'(3) || in_ready !== 1'b1) begin
      bad++; $display("FAIL fullpp_refuse got occ=%0d rdy=%b want 3 1", occupancy, in_ready);
    end
    while (sb.size() > 0) begin
      cyc(1'b0, '0, '0, 1'b1);
      exp_c = sb.pop_front();
      vec++; if (!did_pop || popped !== exp_c) begin bad++; $display("FAIL fullpp_drain got=%h want=%h", popped, exp_c); end
    end
  endtask

  task automatic test_occ1_swap;
    logic [CMD_W-1:0] b;
    b = mk_cmd(16'h3B, 12'h3B, 1'b1);
    cyc(1'b1, mk_cmd(16'h3A, 12'h3A, 1'b0), '0, 1'b0);
    cyc(1'b1, b, '0, 1'b1);
    exp_c = sb.pop_front();
    vec++; if (!did_pop || popped !== exp_c) begin bad++; $display("FAIL swap_pop got=%h want=%h", popped, exp_c); end
    vec++; if (occupancy !== OW'(1) || bank_valid !== 1'b1 || bank_cmd !== b) begin
      bad++; $display("FAIL swap_head got occ=%0d v=%b cmd=%h want 1 1 %h", occupancy, bank_valid, bank_cmd, b);
    end
    cyc(1'b0, '0, '0, 1'b1);
    exp_c = sb.pop_front();
    vec++; if (!did_pop || popped !== exp_c) begin bad++; $display("FAIL swap_drain got=%h want=%h", popped, exp_c); end
  endtask

  task automatic test_bank_err;
    cyc(1'b1, mk_cmd(16'h4, 12'h4, 1'b0), 3'd1, 1'b0);
    vec++; if (occupancy !== '0 || empty !== 1'b1 || bank_err !== 1'b1) begin
      bad++; $display("FAIL wrong_bank got occ=%0d e=%b err=%b want 0 1 1", occupancy, empty, bank_err);
    end
    cyc(1'b0, '0, '0, 1'b1);
    vec++; if (occupancy !== '0 || bank_valid !== 1'b0 || bank_err !== 1'b1) begin
      bad++; $display("FAIL accept_empty got occ=%0d v=%b err=%b want 0 0 1", occupancy, bank_valid, bank_err);
    end
    repeat (3) cyc(1'b0, '0, '0, 1'b0);
    vec++; if (bank_err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b want=1", bank_err); end
  endtask

  task automatic test_hold_and_reset;
    logic [CMD_W-1:0] g1;
    g1 = mk_cmd(16'h51, 12'h51, 1'b1);
    cyc(1'b1, g1, '0, 1'b0);
    cyc(1'b1, mk_cmd(16'h52, 12'h52, 1'b0), '0, 1'b0);
    for (int i = 0; i < 50; i++) begin
      cyc(1'b0, '0, '0, 1'b0);
      vec++; if (bank_cmd !== g1 || occupancy !== OW'(2)) begin
        bad++; $display("FAIL hold%0d got cmd=%h occ=%0d want %h 2", i, bank_cmd, occupancy, g1);
      end
    end
    #1 rst = 1'b1;
    #1;
    vec++; if (occupancy !== '0 || {empty, full, in_ready, bank_valid, bank_err} !== 5'b10100
               || bank_cmd !== '0) begin
      bad++; $display("FAIL async_rst got occ=%0d flags=%b cmd=%h want 0 10100 0",
                      occupancy, {empty, full, in_ready, bank_valid, bank_err}, bank_cmd);
    end
    sb.delete(); m_occ = 0;
    @(posedge clk); #1 rst = 1'b0;
    cyc(1'b1, mk_cmd(16'h61, 12'h61, 1'b0), '0, 1'b0);
    cyc(1'b0, '0, '0, 1'b1);
    exp_c = sb.pop_front();
    vec++; if (!did_pop || popped !== exp_c) begin bad++; $display("FAIL post_rst got=%h want=%h", popped, exp_c); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_full_pushpop();
    test_occ1_swap();
    test_bank_err();
    test_hold_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
